// File: rtl/uart_rx_frame.sv
// Configurable UART receiver: synchroniser, 3-sample majority vote, false-start/break handling.
// Frames land in a small FIFO drained over valid/ready; overflowing frames are dropped and flagged.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 1042,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bits,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_perr,
   output logic                 m_ferr,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 ovr,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   logic [1:0]           sync_q;
   logic [2:0]           samp_q;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 push;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_q, rd_q;
   logic                 ovr_q;

   logic maj, fall, mid, par_x, full, empty, pop, do_push;

   assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   assign fall  = samp_q[0] & ~sync_q[1];
   assign mid   = (cnt_q == MID);
   assign par_x = (^shreg_q) ^ maj;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = S_START;
               bit_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: if (mid) state_d = maj ? S_IDLE : S_DATA;
         S_DATA: if (mid) begin
            shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'(DATA_BITS - 1)) begin
               bit_d   = '0;
               state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
         end
         S_PAR: if (mid) begin
            perr_d  = (PARITY == 1) ? par_x : ~par_x;
            state_d = S_STOP;
         end
         S_STOP: if (mid) begin
            ferr_d = ferr_q | ~maj;
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'(STOP_BITS - 1)) begin
               // A low stop bit may be a break: park until the line returns high.
               push    = 1'b1;
               bit_d   = '0;
               state_d = ferr_d ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_d = '0;
            if (maj) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop     = !empty && m_ready;
   assign do_push = push && (!full || pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '1;
         samp_q  <= '1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync_q  <= {sync_q[0], bits};
         samp_q  <= {samp_q[1:0], sync_q[1]};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= push && full && !pop;
         // At full with a pop, the write slot is the head being consumed this cycle.
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= {shreg_q, perr_d, ferr_d};
            wr_q <= wr_q + (AW+1)'(1);
         end
         if (pop) rd_q <= rd_q + (AW+1)'(1);
      end
   end

   assign {m_data, m_perr, m_ferr} = mem_q[rd_q[AW-1:0]];
   assign m_valid = !empty;
   assign ovr     = ovr_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench: three receiver configurations share one clock and reset, each with its own line.
module tb_uart_rx_frame;

   logic       clk;
   logic       rst;
   logic       line [3];
   logic       ready0, ready1, ready2;

   logic [7:0] m_data0, m_data2;
   logic [6:0] m_data1;
   logic       m_perr0, m_ferr0, m_valid0, ovr0, busy0;
   logic       m_perr1, m_ferr1, m_valid1, ovr1, busy1;
   logic       m_perr2, m_ferr2, m_valid2, ovr2, busy2;

   int checks = 0;
   int errors = 0;

   int q0 [$];
   int q1 [$];
   int q2 [$];
   int vcnt0 = 0;
   int ovr_cyc2 = 0;
   int busy_cyc2 = 0;

   uart_rx_frame u0 (
      .clk(clk), .rst(rst), .bits(line[0]),
      .m_data(m_data0), .m_perr(m_perr0), .m_ferr(m_ferr0), .m_valid(m_valid0),
      .m_ready(ready0), .ovr(ovr0), .busy(busy0)
   );

   uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .bits(line[1]),
      .m_data(m_data1), .m_perr(m_perr1), .m_ferr(m_ferr1), .m_valid(m_valid1),
      .m_ready(ready1), .ovr(ovr1), .busy(busy1)
   );

   uart_rx_frame #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst), .bits(line[2]),
      .m_data(m_data2), .m_perr(m_perr2), .m_ferr(m_ferr2), .m_valid(m_valid2),
      .m_ready(ready2), .ovr(ovr2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (m_valid0 && ready0) q0.push_back(int'({m_data0, m_perr0, m_ferr0}));
      if (m_valid1 && ready1) q1.push_back(int'({m_data1, m_perr1, m_ferr1}));
      if (m_valid2 && ready2) q2.push_back(int'({m_data2, m_perr2, m_ferr2}));
      if (m_valid0) vcnt0++;
      if (ovr2) ovr_cyc2++;
      if (busy2) busy_cyc2++;
   end

   function automatic int fr(input int d, input int p, input int f);
      return (d << 2) | (p << 1) | f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic take(input int idx, output logic [31:0] v);
      v = 32'hFFFF_FFFF;
      case (idx)
         0: if (q0.size() > 0) v = q0.pop_front();
         1: if (q1.size() > 0) v = q1.pop_front();
         default: if (q2.size() > 0) v = q2.pop_front();
      endcase
   endtask

   task automatic send(input int idx, input int cpb, input logic [8:0] d, input int nb,
                       input bit has_par, input logic pbit, input int nstop);
      line[idx] = 1'b0;
      hold(cpb);
      for (int i = 0; i < nb; i++) begin
         line[idx] = d[i];
         hold(cpb);
      end
      if (has_par) begin
         line[idx] = pbit;
         hold(cpb);
      end
      for (int i = 0; i < nstop; i++) begin
         line[idx] = 1'b1;
         hold(cpb);
      end
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  a5;
      int          snap;
      int          n;

      rst = 1'b0;
      line[0] = 1'b1; line[1] = 1'b1; line[2] = 1'b1;
      ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
      hold(5);
      chk("rst_valid", {31'd0, m_valid2}, 0);
      chk("rst_data", {24'd0, m_data2}, 0);
      chk("rst_flags", {30'd0, m_perr2, m_ferr2}, 0);
      chk("rst_ovr", {31'd0, ovr2}, 0);
      chk("rst_busy", {29'd0, busy0, busy1, busy2}, 0);
      rst = 1'b1;
      hold(10);

      // 8N1 at the default bit rate
      send(0, 1042, 9'h03F, 8, 1'b0, 1'b0, 1);
      hold(40);
      take(0, v);
      chk("8n1_frame", v, fr(8'h3F, 0, 0));
      chk("8n1_count", q0.size(), 0);
      chk("8n1_valid_cycles", vcnt0, 1);

      // 7E2: good and bad parity
      send(1, 16, 9'h055, 7, 1'b1, 1'b0, 2);
      hold(20);
      take(1, v);
      chk("7e2_good", v, fr(8'h55, 0, 0));
      send(1, 16, 9'h055, 7, 1'b1, 1'b1, 2);
      hold(20);
      take(1, v);
      chk("7e2_bad_parity", v, fr(8'h55, 1, 0));
      chk("7e2_count", q1.size(), 0);

      // Short glitch is rejected as a false start
      snap = busy_cyc2;
      line[2] = 1'b0;
      hold(4);
      line[2] = 1'b1;
      n = 0;
      while (n < 16 && busy2) begin
         hold(1);
         n++;
      end
      chk("glitch_busy_seen", {31'd0, (busy_cyc2 - snap) > 0}, 1);
      chk("glitch_busy_clear", {31'd0, busy2}, 0);
      hold(40);
      chk("glitch_no_frame", q2.size(), 0);

      // Break: one frame with ferr, then normal reception resumes
      line[2] = 1'b0;
      hold(480);
      line[2] = 1'b1;
      hold(100);
      take(2, v);
      chk("break_frame", v, fr(0, 0, 1));
      chk("break_single", q2.size(), 0);
      chk("break_idle", {31'd0, busy2}, 0);
      send(2, 16, 9'h05A, 8, 1'b0, 1'b0, 1);
      hold(20);
      take(2, v);
      chk("after_break", v, fr(8'h5A, 0, 0));

      // Overrun: fifth frame into a full FIFO is dropped
      ready2 = 1'b0;
      snap = ovr_cyc2;
      for (int k = 1; k <= 4; k++) send(2, 16, 9'(k), 8, 1'b0, 1'b0, 1);
      hold(10);
      chk("ovr_before_5", ovr_cyc2 - snap, 0);
      send(2, 16, 9'h005, 8, 1'b0, 1'b0, 1);
      hold(10);
      chk("ovr_pulse", ovr_cyc2 - snap, 1);
      chk("ovr_valid_held", {31'd0, m_valid2}, 1);
      ready2 = 1'b1;
      hold(10);
      for (int k = 1; k <= 4; k++) begin
         take(2, v);
         chk($sformatf("drain_%0d", k), v, fr(k, 0, 0));
      end
      chk("drain_empty", q2.size(), 0);
      chk("drain_valid_low", {31'd0, m_valid2}, 0);

      // Reset during bit 3 of 0xA5, then 0xC3
      a5 = 8'hA5;
      line[2] = 1'b0;
      hold(16);
      for (int i = 0; i < 3; i++) begin
         line[2] = a5[i];
         hold(16);
      end
      line[2] = a5[3];
      hold(8);
      rst = 1'b0;
      line[2] = 1'b1;
      hold(3);
      chk("midrst_busy", {31'd0, busy2}, 0);
      chk("midrst_valid", {31'd0, m_valid2}, 0);
      rst = 1'b1;
      hold(50);
      chk("midrst_no_frame", q2.size(), 0);
      send(2, 16, 9'h0C3, 8, 1'b0, 1'b0, 1);
      hold(20);
      take(2, v);
      chk("midrst_c3", v, fr(8'hC3, 0, 0));
      chk("midrst_count", q2.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised successor to the fixed 8N1 UART receiver: a configurable serial receiver with selectable data width, parity and stop bits. It adds an input synchroniser, majority-vote sampling, false-start rejection and per-frame error flags. Received frames are buffered in a small FIFO and delivered on a valid/ready stream, so the consumer may stall. It sits between the pad-side serial line and the byte-level protocol logic, replacing the fixed-format receiver.

## Interface
- CLKS_PER_BIT, 1042: clocks per bit period (10 MHz / 9600 baud); legal range ≥ 8.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: frames buffered; power of two, ≥ 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bits  in  1  serial line input; asynchronous to clk; idles high.
- m_data  out  DATA_BITS  received data, LSB = first bit on the line.
- m_perr  out  1  parity error flag for the frame at the FIFO head (always 0 when PARITY = 0).
- m_ferr  out  1  framing error flag for the frame at the FIFO head (a stop bit sampled 0).
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts; a pop occurs when m_valid && m_ready.
- ovr  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- busy  out  1  high in every state other than IDLE.

## Operation
- Input conditioning: two-flop synchroniser on bits, feeding a 3-entry sample shift register. The sampled bit value is the majority of the last 3 synchronised samples.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1. The mid-bit sample point is count == CLKS_PER_BIT/2.
- States:
  - IDLE: on a synchronised falling edge (1→0), clear the counter and go to START.
  - START: at mid-bit, if the majority value is 0 go to DATA; otherwise it is a false start, return to IDLE with nothing pushed.
  - DATA: sample DATA_BITS bits at each mid-bit, shifting in LSB first. Then go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample 1 bit. Parity error condition:
    - even mode: XOR of data bits and the parity bit ≠ 0;
    - odd mode: that XOR ≠ 1.
  - STOP: sample STOP_BITS bits. Any stop bit sampled 0 sets ferr.
    - At the mid-bit of the last stop bit, push {data, perr, ferr} to the FIFO.
    - If ferr = 0, go to IDLE (this allows resync for back-to-back frames).
    - If ferr = 1, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the majority value is 1, then go to IDLE. This handles break conditions: one frame is pushed, with no repeated frames.
- Push behaviour:
  - A frame is pushed even when its perr or ferr flag is set.
  - If the FIFO is full at push time and no pop occurs in the same cycle, the frame is dropped and ovr pulses.
- FIFO: simultaneous push and pop at full is allowed (no overrun). A pop when empty is ignored. m_data, m_perr and m_ferr are valid only while m_valid = 1; they are the head entry, registered.

## Timing
- Reset values:
  - m_valid = 0, m_data = 0, m_perr = 0, m_ferr = 0, ovr = 0, busy = 0;
  - state = IDLE, FIFO empty;
  - synchroniser and sample register = all 1s.
- Reset asserted mid-frame aborts the frame immediately. After release, the receiver waits for the next falling edge.
- Detection latency: the falling edge on bits is seen 2 cycles later (synchroniser). The majority value lags by up to 1 further cycle.
- Push occurs at the mid-point of the last stop bit, about (1 + DATA_BITS + P + STOP_BITS − 0.5)·CLKS_PER_BIT + 3 cycles after the start edge, where P is 1 if parity is enabled, else 0.
- m_valid rises the cycle after the push into an empty FIFO.
- Pop takes effect on the clock edge where m_valid && m_ready. The next entry appears in the following cycle, so full throughput is 1 frame per cycle.
- ovr is asserted for exactly 1 cycle, in the cycle after the dropped push.

## Test plan
- Defaults, with m_ready = 1: send 0x3F as 8N1 -> one frame, m_data = 0x3F, m_perr = 0, m_ferr = 0; m_valid high for 1 cycle.
- DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, CLKS_PER_BIT = 16:
  - send 0x55 with correct parity bit 0 -> m_data = 0x55, m_perr = 0;
  - send 0x55 with parity bit 1 -> m_perr = 1, data still 0x55.
- Glitch: drive bits low for CLKS_PER_BIT/4 cycles, then high -> no push, busy returns to 0 within CLKS_PER_BIT cycles.
- Break: hold bits low for 3 frame times, then high -> exactly one frame, m_data = 0x00, m_ferr = 1; no further frames until the line has idled and a new start bit arrives.
- Overrun: FIFO_DEPTH = 4, m_ready = 0, send 0x01..0x05 back-to-back -> ovr pulses once, on frame 0x05. Then m_ready = 1 -> pops 0x01, 0x02, 0x03, 0x04 in order, then m_valid = 0.
- Reset mid-frame: assert rst low during bit 3 of 0xA5, release, then send 0xC3 -> only 0xC3 is received, with no error flags.
